// File: rtl/reverb_pkg.sv
// Shared definitions for the reverb signal path: sample type, saturating adder
// and the pre-delay sequencer state encoding.
package reverb_pkg;

  localparam int DATA_W = 20;

  typedef logic signed [DATA_W-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = sample_t'({1'b0, {(DATA_W-1){1'b1}}});
  localparam sample_t SAMPLE_MIN = sample_t'({1'b1, {(DATA_W-1){1'b0}}});

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // Sum at DATA_W+1 bits; disagreeing top two bits mean overflow, clamp by sign.
  function automatic sample_t sat_add(input sample_t a, input sample_t b);
    logic signed [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] != sum[DATA_W-1])
      sat_add = sum[DATA_W] ? SAMPLE_MIN : SAMPLE_MAX;
    else
      sat_add = sample_t'(sum[DATA_W-1:0]);
  endfunction

endpackage

// File: rtl/predelay_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Contents are not reset; the clear sequencer in the top level zeroes them.
module predelay_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/reverb_predelay.sv
// Programmable pre-delay with optional attenuated feedback echo, feeding the
// reverb core. A clear pass zeroes the buffer after every reset.
//
//   state    | meaning
//   ST_CLEAR | writing 0 to every buffer address, output forced to 0
//   ST_RUN   | one sample per cycle in and out, delay/feedback active
module reverb_predelay
  import reverb_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                     CLOCK48kHz,
  input  logic                     RESET,
  input  logic signed [DATA_W-1:0] audioIn,
  input  logic [ADDR_W-1:0]        delaySamples,
  input  logic [2:0]               fbShift,
  output logic signed [DATA_W-1:0] audioOut,
  output logic                     ready
);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clearCnt;
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdAddr;
  logic [ADDR_W-1:0] ramWrAddr;
  logic              ramWrEn;
  sample_t           ramWrData;
  sample_t           ramRdData;
  sample_t           fbSample;
  sample_t           wSample;
  sample_t           bypassReg;
  logic              outZero;
  logic              outBypass;

  always_comb begin
    fbSample = '0;
    if (fbShift != 3'd0 && delaySamples != '0)
      fbSample = audioOut >>> fbShift;
    wSample = sat_add(audioIn, fbSample);
    rdAddr  = wrPtr - delaySamples;
  end

  always_comb begin
    ramWrEn   = !RESET;
    ramWrAddr = wrPtr;
    ramWrData = wSample;
    if (state == ST_CLEAR) begin
      ramWrAddr = clearCnt;
      ramWrData = '0;
    end
  end

  predelay_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) uRam (
    .clk    (CLOCK48kHz),
    .wrEn   (ramWrEn),
    .wrAddr (ramWrAddr),
    .wrData (ramWrData),
    .rdAddr (rdAddr),
    .rdData (ramRdData)
  );

  // Output select flags are registered alongside the RAM read, so the muxed
  // result only changes on the clock edge.
  always_comb begin
    audioOut = ramRdData;
    if (outZero)        audioOut = '0;
    else if (outBypass) audioOut = bypassReg;
  end

  always_ff @(posedge CLOCK48kHz) begin
    if (RESET) begin
      state     <= ST_CLEAR;
      clearCnt  <= '0;
      wrPtr     <= '0;
      outZero   <= 1'b1;
      outBypass <= 1'b0;
      bypassReg <= '0;
      ready     <= 1'b0;
    end else begin
      ready <= (state == ST_RUN);
      if (state == ST_CLEAR) begin
        clearCnt <= clearCnt + 1'b1;
        outZero  <= 1'b1;
        if (clearCnt == {ADDR_W{1'b1}}) state <= ST_RUN;
      end else begin
        wrPtr     <= wrPtr + 1'b1;
        outZero   <= 1'b0;
        outBypass <= (delaySamples == '0);
        bypassReg <= audioIn;
      end
    end
  end

endmodule

// File: doc/reverb_predelay.md
# reverb_predelay

Programmable pre-delay line with optional feedback echo, sitting directly upstream of the Schroeder reverb core. It takes one 20-bit signed sample per CLOCK48kHz cycle, delays it by a runtime-selectable number of samples through a circular RAM buffer, and presents the result to the reverb's audio input. After every reset a clear sequencer zeroes the buffer, so no stale audio reaches the reverb.

## Interface
- DATA_W, 20, sample width, two's complement signed
- ADDR_W, 10, buffer address width; DEPTH = 2^ADDR_W = 1024 samples (≈21.3 ms at 48 kHz)
- CLOCK48kHz  in  1  sample clock; one sample per rising edge
- RESET  in  1  synchronous, active-high; sampled on the CLOCK48kHz rising edge
- audioIn  in  DATA_W  signed input sample
- delaySamples  in  ADDR_W  delay d, 0..DEPTH-1; sampled every cycle
- fbShift  in  3  feedback attenuation k; 0 = feedback off, 1..7 = feed back audioOut >>> k
- audioOut  out  DATA_W  signed delayed sample, registered
- ready  out  1  high in RUN, low while the buffer is clearing

## Operation
- FSM states: CLEAR, RUN.
- RESET high: state←CLEAR, clear counter←0, wr_ptr←0, audioOut←0, ready←0. RESET wins over everything, including a reset asserted mid-RUN or mid-CLEAR; in that case the clear restarts from address 0.
- CLEAR: write 0 to mem[clear counter] and increment, one address per cycle. audioIn, delaySamples and fbShift are ignored, audioOut holds 0 and ready holds 0. After address DEPTH-1 is written, move to RUN.
- RUN, cycle t:
  - w(t) = sat(audioIn(t) + fb(t)).
  - fb(t) = (k≠0 and d≠0) ? audioOut(t) >>> k : 0, using an arithmetic shift.
  - mem[wr_ptr] ← w(t).
  - Read address = (wr_ptr − d) mod DEPTH.
  - wr_ptr ← wr_ptr + 1, wrapping from DEPTH-1 to 0.
- Output for d ≥ 1: audioOut(t+1) = w(t−d), taken from the synchronous RAM read. The read address never equals the write address.
- Output for d = 0: audioOut(t+1) = audioIn(t) through a bypass register, and feedback is forced off.
- Arithmetic:
  - Sum is formed at DATA_W+1 bits.
  - sat() clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1], i.e. [−524288, 524287]. There is no wrap-around.
  - Shift is arithmetic, so negative values round toward −∞.
- Echo period with feedback is d+1 samples. Each repeat is scaled by 2^−k.
- Delay change in RUN takes effect on the next read with no smoothing. Clicks are acceptable, and any samples read come from valid buffer contents.
- After CLEAR, locations not yet written since the clear read as 0. Output ramps in from silence.

## Timing
- Reset values: audioOut = 0, ready = 0.
- RESET deasserted at edge e0: CLEAR occupies edges e0..e0+DEPTH−1, and ready rises at edge e0+DEPTH.
- The first RUN sample is accepted at edge e0+DEPTH.
- Latency from audioIn to audioOut is d+1 edges. For d = 0 it is 1 edge.
- Throughput is one sample per cycle with no stalls in RUN. ready is status only; there is no handshake back-pressure.
- Inputs are sampled on the rising edge. audioOut changes only on the rising edge.

## Structure
- Shared package reverb_pkg holds:
  - DATA_W, and the sample typedef (signed [DATA_W-1:0]);
  - the sat_add function (DATA_W+1 → DATA_W clamp);
  - the FSM state encoding (CLEAR, RUN).
  - The reverb core and its combs and all-passes reuse sat_add.
- Sub-module predelay_ram:
  - simple dual-port RAM, DEPTH × DATA_W;
  - one write port, one synchronous read port with 1-cycle read latency;
  - no reset on the contents.
- Top level holds the FSM, clear counter, wr_ptr, read-address subtractor, bypass mux, and feedback adder/saturator.

## Test plan
- Reset/clear: pulse RESET for 3 cycles, then hold audioIn = 4095. Required: ready = 0 and audioOut = 0 for exactly 1024 cycles, then ready = 1. audioOut stays 0 until d+1 cycles after the first RUN sample.
- Impulse, d = 10, k = 0: audioIn = 4095 for one cycle at RUN edge t0. Required: audioOut = 4095 only at edge t0+11, and 0 at every other edge for 2048 cycles.
- Bypass, d = 0, k = 3: drive a ramp 0, 1, 2, … Required: audioOut equals the ramp delayed by exactly 1 edge, with no feedback contribution.
- Feedback echo, d = 9, k = 1: single impulse of 4096 at t0. Required: audioOut = 4096 at t0+10, 2048 at t0+20, 1024 at t0+30, …, 1 at t0+130, then 0.
- Saturation, d = 4, k = 1: audioIn held at 524287. Required: audioOut settles at 524287 and never goes negative. Repeat with −524288: it holds −524288.
- Reset mid-operation and wrap: run d = 1023 past at least two wr_ptr wraps, checking audioOut(t+1024) = audioIn(t). Then assert RESET for 1 cycle mid-stream. Required: 1024 more CLEAR cycles, then output 0 until the new samples arrive 1024 edges later.
